// File: rtl/cb_seg_pkg.sv
// Shared types and widths for the code block segmentation input side.
package cb_seg_pkg;

  localparam int unsigned TB_SIZE_W = 12;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_SRC   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIZE = 2'd1,
    ST_DATA = 2'd2
  } ld_state_e;

  function automatic logic [NUM_SRC-1:0] src_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tb_loader_arb_if.sv
// Source/segmentation signal bundle of tb_loader_arb; slave = loader side, master = environment side.
interface tb_loader_arb_if;
  import cb_seg_pkg::*;

  logic [NUM_SRC-1:0]   req;
  logic [TB_SIZE_W-1:0] size0;
  logic [TB_SIZE_W-1:0] size1;
  logic [NUM_SRC-1:0]   ack;
  logic [BYTE_W-1:0]    src_data0;
  logic [BYTE_W-1:0]    src_data1;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_ready;
  logic [TB_SIZE_W-1:0] tb_size_in;
  logic                 wreq_size;
  logic [BYTE_W-1:0]    tb_in;
  logic                 wreq_data;
  logic                 tb_done;
  logic                 busy;
  logic                 err;

  modport slave (
    input  req, size0, size1, src_data0, src_data1, src_valid, tb_done,
    output ack, src_ready, tb_size_in, wreq_size, tb_in, wreq_data, busy, err
  );

  modport master (
    output req, size0, size1, src_data0, src_data1, src_valid, tb_done,
    input  ack, src_ready, tb_size_in, wreq_size, tb_in, wreq_data, busy, err
  );

endinterface

// File: rtl/tb_loader_arb_rr_arb2.sv
// Two-requester round-robin grant; the pointer names the favoured source and flips past each winner on advance.
module rr_arb2
  import cb_seg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               advance_i,
  output logic               gnt_valid_o,
  output logic               gnt_idx_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = (req_i == 2'b11) ? ptr_q : req_i[1];
    ptr_d       = ptr_q;
    if (advance_i && gnt_valid_o) begin
      ptr_d = ~gnt_idx_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tb_loader_arb.sv
// Round-robin TB loader: grants one of two sources, writes its size, then streams its bytes under a credit limit.
// Optional stall supervision with zero-fill is enabled by defining TB_LOADER_TIMEOUT_EN.
module tb_loader_arb
  import cb_seg_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYC     = 255
) (
  input  logic            clk,
  input  logic            reset,
  tb_loader_arb_if.slave  bus
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  if (MAX_OUTSTANDING < 1) begin : g_bad_credit
    $error("MAX_OUTSTANDING must be at least 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  ld_state_e            state_q, state_d;
  logic                 src_q, src_d;
  logic [TB_SIZE_W-1:0] size_q, size_d;
  logic [TB_SIZE_W-1:0] rem_q, rem_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic [NUM_SRC-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic [BYTE_W-1:0]    tb_in_q, tb_in_d;
  logic                 wreq_data_q, wreq_data_d;

  logic [NUM_SRC-1:0]   elig;
  logic                 credit_ok;
  logic                 gnt_valid;
  logic                 gnt_idx;
  logic [TB_SIZE_W-1:0] gnt_size;
  logic [BYTE_W-1:0]    sel_data;
  logic                 sel_valid;
  logic                 ready_en;
  logic                 xfer;
  logic                 flush_q;
  logic                 to_fire;

  // A source whose ack is still in flight is masked so a held req is not granted twice.
  assign credit_ok = (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign elig      = (state_q == ST_IDLE && credit_ok) ? (bus.req & ~ack_q) : '0;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (reset),
    .req_i       (elig),
    .advance_i   (gnt_valid),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign gnt_size  = gnt_idx ? bus.size1 : bus.size0;
  assign sel_data  = src_q ? bus.src_data1 : bus.src_data0;
  assign sel_valid = src_q ? bus.src_valid[1] : bus.src_valid[0];
  assign ready_en  = (state_q == ST_DATA) && (rem_q != '0) && !flush_q;
  assign xfer      = ready_en && sel_valid;

`ifdef TB_LOADER_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    to_fire = 1'b0;
    if (state_q != ST_DATA) begin
      stall_d = '0;
      flush_d = 1'b0;
    end else if (xfer) begin
      stall_d = '0;
    end else if (!flush_q) begin
      if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
        to_fire = 1'b1;
        flush_d = 1'b1;
        stall_d = '0;
      end else begin
        stall_d = stall_q + STALL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
`else
  assign flush_q = 1'b0;
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    size_d      = size_q;
    rem_d       = rem_q;
    ack_d       = '0;
    err_d       = 1'b0;
    tb_in_d     = tb_in_q;
    wreq_data_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          ack_d = src_onehot(gnt_idx);
          if (gnt_size == '0) begin
            err_d = 1'b1;
          end else begin
            src_d   = gnt_idx;
            size_d  = gnt_size;
            state_d = ST_SIZE;
          end
        end
      end
      ST_SIZE: begin
        rem_d   = size_q;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        // After a stall timeout the remaining bytes are zero-filled so the size contract still holds.
        if (xfer || flush_q) begin
          tb_in_d     = xfer ? sel_data : '0;
          wreq_data_d = 1'b1;
          rem_d       = rem_q - TB_SIZE_W'(1);
          if (rem_q == TB_SIZE_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
        if (to_fire) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if ((state_q == ST_SIZE) && !(bus.tb_done && outstanding_q != '0)) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if ((state_q != ST_SIZE) && bus.tb_done && outstanding_q != '0) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      src_q         <= 1'b0;
      size_q        <= '0;
      rem_q         <= '0;
      outstanding_q <= '0;
      ack_q         <= '0;
      err_q         <= 1'b0;
      tb_in_q       <= '0;
      wreq_data_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      size_q        <= size_d;
      rem_q         <= rem_d;
      outstanding_q <= outstanding_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      tb_in_q       <= tb_in_d;
      wreq_data_q   <= wreq_data_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.src_ready  = ready_en ? src_onehot(src_q) : '0;
  assign bus.tb_size_in = size_q;
  assign bus.wreq_size  = (state_q == ST_SIZE);
  assign bus.tb_in      = tb_in_q;
  assign bus.wreq_data  = wreq_data_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_tb_loader_arb.sv
// Directed and randomized bench for tb_loader_arb; source agents feed queued TBs, a negedge monitor logs outputs.
`timescale 1ns/1ps
module tb_tb_loader_arb;
  import cb_seg_pkg::*;

`ifdef TB_LOADER_TIMEOUT_EN
  localparam int unsigned TO_CYC = 4;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  tb_loader_arb_if bus();

  tb_loader_arb #(.MAX_OUTSTANDING(2), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source agent state and stimulus queues (pushed by the main sequence, consumed by index).
  int          psize [2][$];
  logic [7:0]  pdata [2][$];
  logic [7:0]  last_tb [2][$];
  int          ps_rd [2] = '{0, 0};
  int          pd_rd [2] = '{0, 0};
  int          phase [2] = '{0, 0};
  int          left [2]  = '{0, 0};
  int          sent [2]  = '{0, 0};
  int          vprob [2] = '{100, 100};
  int          stall_after [2] = '{1000, 1000};
  bit          took [2];
  logic [1:0]  req_v = '0;
  logic [1:0]  valid_v = '0;
  logic [11:0] sz_v [2] = '{12'd0, 12'd0};
  logic [7:0]  dat_v [2] = '{8'd0, 8'd0};
  logic        tb_done_v = 1'b0;

  assign bus.req       = req_v;
  assign bus.size0     = sz_v[0];
  assign bus.size1     = sz_v[1];
  assign bus.src_data0 = dat_v[0];
  assign bus.src_data1 = dat_v[1];
  assign bus.src_valid = valid_v;
  assign bus.tb_done   = tb_done_v;

  // Monitor logs
  logic [7:0] got_b [$];
  int         got_bc [$];
  int         got_s [$];
  int         got_sc [$];
  int         ack_n [2] = '{0, 0};
  int         ack_c [2] = '{0, 0};
  int         err_n = 0;
  int         err_c = 0;
  int         busy_n = 0;
  int         ready_viol = 0;

  task automatic drive_byte(input int s);
    valid_v[s] = (sent[s] < stall_after[s]) && ($urandom_range(99) < vprob[s]);
    dat_v[s]   = pdata[s][pd_rd[s]];
  endtask

  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        phase[s] = 0; left[s] = 0; sent[s] = 0;
        ps_rd[s] = psize[s].size();
        pd_rd[s] = pdata[s].size();
        req_v[s] = 1'b0; valid_v[s] = 1'b0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        case (phase[s])
          0: if (ps_rd[s] < psize[s].size()) begin
               left[s] = psize[s][ps_rd[s]];
               ps_rd[s]++;
               sz_v[s] = 12'(left[s]);
               req_v[s] = 1'b1;
               phase[s] = 1;
             end
          1: if (bus.ack[s]) begin
               req_v[s] = 1'b0;
               sent[s] = 0;
               if (left[s] == 0) phase[s] = 3;
               else begin phase[s] = 2; drive_byte(s); end
             end
          2: begin
               if (took[s]) begin pd_rd[s]++; left[s]--; sent[s]++; end
               if (left[s] == 0) begin valid_v[s] = 1'b0; phase[s] = 0; end
               else drive_byte(s);
             end
          default: phase[s] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      took[s] = bus.src_valid[s] && bus.src_ready[s];
      if (!reset) begin
        if (bus.src_ready[s] && phase[s] != 2) ready_viol++;
        if (bus.ack[s]) begin ack_n[s]++; ack_c[s] = cyc; end
      end
    end
    if (!reset) begin
      if (bus.wreq_data) begin got_b.push_back(bus.tb_in); got_bc.push_back(cyc); end
      if (bus.wreq_size) begin got_s.push_back(int'(bus.tb_size_in)); got_sc.push_back(cyc); end
      if (bus.err) begin err_n++; err_c = cyc; end
      if (bus.busy) busy_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic push_tb(input int s, input int n, input logic [7:0] b0, input bit rnd);
    logic [7:0] b;
    last_tb[s].delete();
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : b0 + 8'(i);
      pdata[s].push_back(b);
      last_tb[s].push_back(b);
    end
    psize[s].push_back(n);
  endtask

  task automatic done_pulse();
    tb_done_v = 1'b1;
    tick(1);
    tb_done_v = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int maxc);
    int k;
    k = 0;
    while (!(phase[0] == 0 && phase[1] == 0 && ps_rd[0] == psize[0].size() &&
             ps_rd[1] == psize[1].size() && !bus.busy) && k < maxc) begin
      tick(1);
      k++;
    end
    chk(tag, 32'(k < maxc), 32'd1);
    tick(2);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
    chk({tag, "_ready"}, 32'(bus.src_ready), 32'd0);
    chk({tag, "_ctl"}, {28'd0, bus.wreq_size, bus.wreq_data, bus.busy, bus.err}, 32'd0);
    chk({tag, "_size"}, 32'(bus.tb_size_in), 32'd0);
    chk({tag, "_byte"}, 32'(bus.tb_in), 32'd0);
    chk({tag, "_credit"}, 32'(dut.outstanding_q), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, s0, a0, a1, e0, bz0, k, dc;
    int ptr, pat, first, g, nz, err_exp, tbs, rb0, rs0, re0, ra0, rv0;
    int tmp_n [2];
    logic [7:0] exp_b [$];
    int exp_s [$];

    // Reset state
    tick(2);
    chk_outputs_zero("reset");
    reset = 1'b0;
    tick(1);

    // Single TB, continuous valid
    b0 = got_b.size(); s0 = got_s.size(); a0 = ack_n[0];
    push_tb(0, 3, 8'hA1, 1'b0);
    wait_quiet("single_done", 50);
    chk("single_nsize", got_s.size() - s0, 1);
    chk("single_size", got_s[s0], 3);
    chk("single_ack", ack_n[0] - a0, 1);
    chk("single_ack_cyc", ack_c[0], got_sc[s0]);
    chk("single_nbytes", got_b.size() - b0, 3);
    for (int i = 0; i < 3; i++) chk("single_byte", got_b[b0 + i], 32'hA1 + i);
    chk("single_lat", got_bc[b0], got_sc[s0] + 2);
    chk("single_burst", got_bc[b0 + 2], got_bc[b0] + 2);
    chk("single_credit", 32'(dut.outstanding_q), 1);
    done_pulse();
    chk("single_credit_ret", 32'(dut.outstanding_q), 0);

    // Simultaneous requests: source 0 first after reset
    apply_reset();
    b0 = got_b.size(); s0 = got_s.size(); rv0 = ready_viol;
    vprob[0] = 60; vprob[1] = 60;
    push_tb(0, 2, 8'h10, 1'b0);
    push_tb(1, 4, 8'h20, 1'b0);
    wait_quiet("simul_done", 200);
    chk("simul_nsize", got_s.size() - s0, 2);
    chk("simul_size0", got_s[s0], 2);
    chk("simul_size1", got_s[s0 + 1], 4);
    chk("simul_nbytes", got_b.size() - b0, 6);
    for (int i = 0; i < 2; i++) chk("simul_byte0", got_b[b0 + i], 32'h10 + i);
    for (int i = 0; i < 4; i++) chk("simul_byte1", got_b[b0 + 2 + i], 32'h20 + i);
    chk("simul_ready_excl", ready_viol - rv0, 0);
    vprob[0] = 100; vprob[1] = 100;

    // Credit limit: third TB waits for tb_done
    apply_reset();
    b0 = got_b.size(); a0 = ack_n[0];
    push_tb(0, 1, 8'h30, 1'b0);
    push_tb(0, 1, 8'h31, 1'b0);
    push_tb(0, 1, 8'h32, 1'b0);
    tick(30);
    chk("credit_held_ack", ack_n[0] - a0, 2);
    chk("credit_full", 32'(dut.outstanding_q), 2);
    chk("credit_held_bytes", got_b.size() - b0, 2);
    dc = cyc;
    done_pulse();
    wait_quiet("credit_done", 50);
    chk("credit_ack3", ack_n[0] - a0, 3);
    chk("credit_ack3_cyc", ack_c[0], dc + 2);
    chk("credit_byte3", got_b[b0 + 2], 32'h32);
    chk("credit_after", 32'(dut.outstanding_q), 2);

    // Zero-size request
    apply_reset();
    s0 = got_s.size(); a1 = ack_n[1]; e0 = err_n; bz0 = busy_n;
    push_tb(1, 0, 8'h00, 1'b0);
    wait_quiet("zero_done", 50);
    chk("zero_ack", ack_n[1] - a1, 1);
    chk("zero_err", err_n - e0, 1);
    chk("zero_err_cyc", err_c, ack_c[1]);
    chk("zero_nsize", got_s.size() - s0, 0);
    chk("zero_busy", busy_n - bz0, 0);
    chk("zero_credit", 32'(dut.outstanding_q), 0);

    // Reset in the middle of DATA
    apply_reset();
    b0 = got_b.size();
    push_tb(0, 5, 8'h40, 1'b0);
    k = 0;
    while (got_b.size() - b0 < 2 && k < 50) begin tick(1); k++; end
    chk("rst_reach", 32'(k < 50), 1);
    reset = 1'b1;
    #1;
    chk_outputs_zero("rst_mid");
    tick(2);
    reset = 1'b0;
    tick(1);
    b0 = got_b.size();
    push_tb(0, 2, 8'h50, 1'b0);
    wait_quiet("rst_new_done", 50);
    chk("rst_new_nbytes", got_b.size() - b0, 2);
    chk("rst_new_byte0", got_b[b0], 32'h50);
    chk("rst_new_byte1", got_b[b0 + 1], 32'h51);
    chk("rst_new_credit", 32'(dut.outstanding_q), 1);

    // Randomized rounds against a round-robin service model
    apply_reset();
    ptr = 0; err_exp = 0; tbs = 0;
    rb0 = got_b.size(); rs0 = got_s.size(); re0 = err_n;
    ra0 = ack_n[0] + ack_n[1]; rv0 = ready_viol;
    for (int r = 0; r < 40; r++) begin
      vprob[0] = int'($urandom_range(100, 30));
      vprob[1] = int'($urandom_range(100, 30));
      pat = int'($urandom_range(3, 1));
      nz = 0;
      for (int s = 0; s < 2; s++) begin
        tmp_n[s] = 0;
        if (pat[s]) begin
          tmp_n[s] = ($urandom_range(6) == 0) ? 0 : int'($urandom_range(6, 1));
          push_tb(s, tmp_n[s], 8'h00, 1'b1);
        end
      end
      first = (pat == 3) ? ptr : ((pat == 1) ? 0 : 1);
      for (int j = 0; j < 2; j++) begin
        g = (j == 0) ? first : 1 - first;
        if (pat[g]) begin
          foreach (last_tb[g][i]) exp_b.push_back(last_tb[g][i]);
          if (tmp_n[g] == 0) err_exp++;
          else begin exp_s.push_back(tmp_n[g]); nz++; end
          ptr = 1 - g;
          tbs++;
        end
      end
      wait_quiet("rnd_done", 300);
      chk("rnd_credit", 32'(dut.outstanding_q), nz);
      repeat (nz) done_pulse();
    end
    chk("rnd_credit_end", 32'(dut.outstanding_q), 0);
    chk("rnd_nbytes", got_b.size() - rb0, exp_b.size());
    for (int i = 0; i < exp_b.size() && rb0 + i < got_b.size(); i++)
      chk("rnd_byte", got_b[rb0 + i], exp_b[i]);
    chk("rnd_nsize", got_s.size() - rs0, exp_s.size());
    for (int i = 0; i < exp_s.size() && rs0 + i < got_s.size(); i++)
      chk("rnd_size", got_s[rs0 + i], exp_s[i]);
    chk("rnd_err", err_n - re0, err_exp);
    chk("rnd_acks", ack_n[0] + ack_n[1] - ra0, tbs);
    chk("rnd_ready_excl", ready_viol - rv0, 0);
    vprob[0] = 100; vprob[1] = 100;

`ifdef TB_LOADER_TIMEOUT_EN
    // Stall timeout with zero fill
    apply_reset();
    b0 = got_b.size(); e0 = err_n;
    stall_after[0] = 1;
    push_tb(0, 3, 8'h60, 1'b0);
    k = 0;
    while (got_b.size() - b0 < 3 && k < 60) begin tick(1); k++; end
    chk("to_reach", 32'(k < 60), 1);
    tick(2);
    chk("to_err", err_n - e0, 1);
    chk("to_nbytes", got_b.size() - b0, 3);
    chk("to_byte0", got_b[b0], 32'h60);
    chk("to_fill1", got_b[b0 + 1], 0);
    chk("to_fill2", got_b[b0 + 2], 0);
    chk("to_err_cyc", err_c, got_bc[b0] + 4);
    chk("to_fill_cyc", got_bc[b0 + 1], err_c + 1);
    chk("to_idle", 32'(bus.busy), 0);
    apply_reset();
    stall_after[0] = 1000;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tb_loader_arb.md
# tb_loader_arb

Input-side scheduler for the code block segmentation datapath. Two transport-block sources (for example two HARQ processes or carriers) compete for the single segmentation input. The block arbitrates between them round-robin, writes the winner's TB size into the size port (`tb_size_in` / `wreq_size`), then streams exactly that many bytes into the data port (`tb_in` / `wreq_data`). A credit counter limits how many TBs are resident downstream at once.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum number of TBs whose size has been written but whose `tb_done` has not yet been received.
- `TIMEOUT_CYC`, default 255: stall limit in cycles. Used only when `TB_LOADER_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `req[1:0]` in 2: per-source TB request, level-sensitive. Held high until `ack` for that source.
- `size0`, `size1` in 12: TB length in bytes. Must be stable while the matching `req` is high.
- `ack[1:0]` out 2: one-cycle pulse when the size is accepted.
- `src_data0`, `src_data1` in 8: per-source byte.
- `src_valid[1:0]` in 2: per-source byte valid.
- `src_ready[1:0]` out 2: per-source byte accept. A byte transfers when valid and ready are both high.
- `tb_size_in` out 12: size to segmentation.
- `wreq_size` out 1: size write strobe.
- `tb_in` out 8: byte to segmentation.
- `wreq_data` out 1: data write strobe.
- `tb_done` in 1: one-cycle pulse from downstream when a TB has been fully consumed.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: one-cycle pulse on a zero-size request or on a timeout.

## Operation
- States are IDLE, SIZE and DATA.
- **IDLE**
  - A source is eligible when its `req` is high and `outstanding < MAX_OUTSTANDING`.
  - The round-robin pointer selects the winner and moves to the other source after each grant.
  - If both sources request, the one not granted most recently wins. After reset the pointer favours source 0.
  - On a grant: latch the source index and its size, pulse `ack[g]`, go to SIZE.
- **Zero size**
  - A grant with size 0 pulses `ack[g]` and `err`.
  - Nothing is written, `outstanding` is unchanged, and the FSM stays in IDLE.
- **SIZE**
  - Drive `wreq_size=1` and `tb_size_in` = the latched size for one cycle.
  - Increment `outstanding`, load `remaining` = size, go to DATA.
- **DATA**
  - `src_ready[g]=1` only while `remaining != 0`. The other source's `src_ready` is 0.
  - Each transfer decrements `remaining`.
  - When the transfer that brings `remaining` to 0 is written, go to IDLE.
- **Credit counter `outstanding`** (width clog2(MAX_OUTSTANDING+1))
  - +1 on a SIZE write; -1 on `tb_done`.
  - Both in the same cycle: no change.
  - `tb_done` while the count is 0 is ignored.
- **Reset mid-TB**: all state clears; the partial TB is discarded. The segmentation block shares the same `reset`, so both sides stay consistent.

## Timing
Reset values of outputs:
- `ack`, `src_ready`, `wreq_size`, `wreq_data`, `busy`, `err` = 0.
- `tb_size_in`, `tb_in` = 0.
- `outstanding` = 0, state = IDLE, pointer = source 0.

Cycle behaviour:
- Grant cycle (IDLE): `ack` is registered and appears the following cycle, together with `wreq_size`. The source may drop `req` after seeing `ack`.
- The `req` → `wreq_size` latency is 1 cycle after the grant evaluation edge.
- `src_ready` is decoded from the registered state and `remaining` only; there is no path from `src_valid`.
- `tb_in` and `wreq_data` are registered: they appear 1 cycle after the valid/ready handshake.
- Maximum throughput is 1 byte per cycle.
- Minimum TB occupancy is size + 2 cycles (SIZE, N×DATA, return to IDLE). There is no bubble between the last data byte and the next grant evaluation.

## Configuration
- With `TB_LOADER_TIMEOUT_EN` defined:
  - A stall counter runs in DATA and clears on every transfer.
  - On reaching `TIMEOUT_CYC` it pulses `err` and drops `src_ready`.
  - It then writes 8'h00 once per cycle until `remaining=0`, so downstream still receives exactly size bytes.
- Without the macro: the counter is absent and DATA waits indefinitely.

## Structure
- Package `cb_seg_pkg`:
  - the state enum;
  - `TB_SIZE_W=12`, `BYTE_W=8`;
  - the NUM_SRC=2 constant.
- One sub-module, `rr_arb2`: a two-requester round-robin grant with an `advance` input that updates the pointer.
- All remaining logic lives in `tb_loader_arb`.

## Test plan
- **Single TB**: `req0` with size 3, bytes A1 A2 A3 valid continuously → `wreq_size` with 3; `tb_in` = A1, A2, A3 on three consecutive cycles; `ack0` pulses once; `outstanding=1`.
- **Simultaneous requests**: `req` = 2'b11, sizes 2 and 4 → source 0 is served first, then source 1. Total `wreq_data` = 6. `src_ready1` is never high during source 0's TB.
- **Credit limit**: MAX_OUTSTANDING=2, three back-to-back TBs, no `tb_done` → the third `ack` is withheld until a `tb_done` pulse, then granted the next cycle.
- **Zero size**: `req1` with size 0 → `ack1` and `err` pulse together; no `wreq_size`; FSM stays in IDLE.
- **Reset mid-DATA**: assert `reset` after 2 of 5 bytes → all outputs 0 at once. After release, a new TB completes normally and `outstanding` starts from 0.
- **Timeout (macro defined, TIMEOUT_CYC=4)**: size 3, one byte then `src_valid` held low → `err` pulses after 4 idle cycles, then two 8'h00 writes, then return to IDLE.
